// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: serialised register-to-register front end for the 4-bit ALU.
// Accepts packed instructions, drives the ALU, writes back and returns the result.
module alu_cmd_sequencer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [8:0]   cmd_instr,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [1:0]   res_rd,
  output logic         busy
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOADI = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0]   op_q;
  logic [1:0]   rd_q;
  logic [W-1:0] cap_q;
  logic [W-1:0] rf [4];

  logic [2:0] op;
  logic [1:0] rd;
  logic [1:0] rs1;
  logic [1:0] rs2;
  logic       accept;

  assign op     = cmd_instr[8:6];
  assign rd     = cmd_instr[5:4];
  assign rs1    = cmd_instr[3:2];
  assign rs2    = cmd_instr[1:0];
  assign accept = (state_q == IDLE) && cmd_valid;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == RESP);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = (op == OP_LOADI) ? WB : EXEC;
        end
      end
      EXEC: state_d = (op_q == OP_NOP) ? IDLE : WB;
      WB:   state_d = RESP;
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      cap_q    <= '0;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      res_data <= '0;
      res_rd   <= '0;
      for (int i = 0; i < 4; i++) begin
        rf[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      // ALU inputs are only non-zero for the single EXEC cycle
      alu_op  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      if (accept) begin
        op_q <= op;
        rd_q <= rd;
        if (op == OP_LOADI) begin
          cap_q <= W'(cmd_instr[3:0]);
        end else begin
          alu_op <= op;
          alu_a  <= rf[rs1];
          alu_b  <= rf[rs2];
        end
      end
      if (state_q == EXEC) begin
        cap_q <= alu_out;
      end
      if (state_q == WB) begin
        rf[rd_q] <= cap_q;
        res_data <= cap_q;
        res_rd   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed table, corner sequences and
// randomized instructions against a register-file reference model.
module tb_alu_cmd_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [8:0]   cmd_instr = '0;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_out;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic [1:0]   res_rd;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;
  int m_rf [4];

  typedef struct {
    logic [8:0] instr;
    logic [3:0] data;
    int         lat;
    int         hold;
  } vec_t;

  vec_t tab [$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_instr (cmd_instr),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_rd    (res_rd),
    .busy      (busy)
  );

  // combinational 4-bit ALU the sequencer drives
  always_comb begin
    alu_out = '0;
    case (alu_op)
      3'd1: alu_out = alu_a + alu_b;
      3'd2: alu_out = alu_a - alu_b;
      3'd3: alu_out = alu_a & alu_b;
      3'd4: alu_out = alu_a | alu_b;
      3'd5: alu_out = ~alu_a;
      3'd6: alu_out = ~alu_b;
      default: alu_out = '0;
    endcase
  end

  function automatic logic [8:0] mk(logic [2:0] o, logic [1:0] d,
                                    logic [1:0] s, logic [1:0] t);
    return {o, d, s, t};
  endfunction

  function automatic logic [8:0] li(logic [1:0] d, logic [3:0] imm);
    return {3'b111, d, imm};
  endfunction

  function automatic void add(logic [8:0] ins, logic [3:0] d,
                              int l, int h);
    vec_t v;
    v.instr = ins;
    v.data  = d;
    v.lat   = l;
    v.hold  = h;
    tab.push_back(v);
  endfunction

  function automatic int lat_of(logic [2:0] o);
    if (o == 3'b000) return 0;
    if (o == 3'b111) return 2;
    return 3;
  endfunction

  function automatic logic [3:0] model(logic [8:0] ins);
    int a;
    int b;
    int r;
    a = m_rf[ins[3:2]];
    b = m_rf[ins[1:0]];
    case (ins[8:6])
      3'd1: r = (a + b) % 16;
      3'd2: r = (a - b + 16) % 16;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = 15 - a;
      3'd6: r = 15 - b;
      3'd7: r = int'(ins[3:0]);
      default: r = 0;
    endcase
    return 4'(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic run(input logic [8:0] ins, input logic [3:0] xd,
                     input int xl, input int hold);
    logic [2:0] op;
    logic [1:0] rd;
    logic [3:0] held;
    int n;
    bit seen;
    op = ins[8:6];
    rd = ins[5:4];
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 1);
    res_ready = (hold == 0);
    cmd_valid = 1'b1;
    cmd_instr = ins;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    seen = 0;
    n = 0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      if (n == 1 && op != 3'b111) begin
        chk("exec_op", 32'(alu_op), 32'(op));
        chk("exec_a", 32'(alu_a), 32'(m_rf[ins[3:2]]));
        chk("exec_b", 32'(alu_b), 32'(m_rf[ins[1:0]]));
        chk("exec_ready", 32'(cmd_ready), 0);
      end
      if (op == 3'b000 && n == 2) begin
        chk("nop_ready", 32'(cmd_ready), 1);
      end
      if (res_valid) seen = 1;
    end
    if (xl == 0) begin
      chk("nop_no_resp", 32'(seen), 0);
      res_ready = 1'b1;
      return;
    end
    chk("resp_latency", 32'(seen ? n : 99), 32'(xl));
    chk("res_data", 32'(res_data), 32'(xd));
    chk("res_rd", 32'(res_rd), 32'(rd));
    chk("alu_idle", {alu_op, alu_a, alu_b}, 0);
    held = res_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_hold", {res_valid, cmd_ready, busy, res_data},
          {1'b1, 1'b0, 1'b1, held});
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs", {cmd_ready, res_valid}, 2'b10);
    m_rf[rd] = int'(model(ins));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_rf[i] = 0;

    add(li(1, 4'h3), 4'h3, 2, 0);
    add(li(0, 4'h3), 4'h3, 2, 0);
    add(li(1, 4'h1), 4'h1, 2, 0);
    add(mk(3'd1, 2, 0, 1), 4'h4, 3, 0);
    add(mk(3'd2, 3, 0, 1), 4'h2, 3, 5);
    add(mk(3'd3, 2, 0, 1), 4'h1, 3, 0);
    add(mk(3'd5, 2, 0, 1), 4'hC, 3, 0);
    add(li(0, 4'h7), 4'h7, 2, 0);
    add(mk(3'd4, 3, 0, 1), 4'h7, 3, 0);
    add(li(0, 4'h3), 4'h3, 2, 0);
    add(li(1, 4'h4), 4'h4, 2, 0);
    add(mk(3'd2, 2, 0, 1), 4'hF, 3, 0);
    add(li(0, 4'hF), 4'hF, 2, 0);
    add(li(1, 4'h1), 4'h1, 2, 0);
    add(mk(3'd1, 2, 0, 1), 4'h0, 3, 0);
    add(mk(3'd6, 3, 0, 1), 4'hE, 3, 0);
    add(mk(3'd0, 3, 0, 1), 4'h0, 0, 0);
    add(mk(3'd4, 2, 3, 3), 4'hE, 3, 0);
    add(li(1, 4'h5), 4'h5, 2, 0);
    add(mk(3'd1, 1, 1, 1), 4'hA, 3, 0);
    add(li(0, 4'h0), 4'h0, 2, 0);
    add(mk(3'd1, 2, 1, 0), 4'hA, 3, 0);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {cmd_ready, busy, res_valid, res_data, res_rd},
        {1'b1, 1'b0, 1'b0, 4'h0, 2'h0});
    chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_outs", {cmd_ready, busy, res_valid, res_data, res_rd},
        {1'b1, 1'b0, 1'b0, 4'h0, 2'h0});

    foreach (tab[i]) begin
      run(tab[i].instr, tab[i].data, tab[i].lat, tab[i].hold);
    end

    // reset while an ADD is in EXEC: no response, no write to r2
    run(li(2, 4'h9), 4'h9, 2, 0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_instr = mk(3'd1, 2, 0, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_exec_busy", {busy, alu_op}, {1'b1, 3'd1});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {cmd_ready, busy, res_valid, alu_op, alu_a, alu_b},
        {1'b1, 1'b0, 1'b0, 11'h0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_rf[i] = 0;
    begin
      bit any;
      any = 0;
      repeat (4) begin
        @(negedge clk);
        if (res_valid) any = 1;
      end
      chk("mid_rst_no_resp", 32'(any), 0);
    end
    run(mk(3'd4, 3, 2, 2), 4'h0, 3, 0);

    for (int i = 0; i < 40; i++) begin
      logic [8:0] ins;
      ins = 9'($urandom_range(0, 511));
      run(ins, model(ins), lat_of(ins[8:6]), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
